// File: rtl/hmc_rf_access_master_if.sv
// hmc_rf_access_master_if: request/response handshake and RF enable bus of the HMC RF access master
//  Parameters: HMC_RF_AWIDTH (address), HMC_RF_WWIDTH (write data), HMC_RF_RWIDTH (read data)
//  req_*  : request channel (valid/ready), write flag, address, write data
//  resp_* : response channel (valid/ready), read data, error, timeout
//  rf_*   : controller register-file port (address, write data, enables, read data, status)
//  modport master: the access master's view; modport slave: the host/RF environment's view
interface hmc_rf_access_master_if #(
    parameter int HMC_RF_AWIDTH = 4,
    parameter int HMC_RF_WWIDTH = 64,
    parameter int HMC_RF_RWIDTH = 64
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [HMC_RF_AWIDTH-1:0] req_address;
    logic [HMC_RF_WWIDTH-1:0] req_wdata;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [HMC_RF_RWIDTH-1:0] resp_rdata;
    logic                     resp_error;
    logic                     resp_timeout;
    logic [HMC_RF_AWIDTH-1:0] rf_address;
    logic [HMC_RF_WWIDTH-1:0] rf_write_data;
    logic                     rf_read_en;
    logic                     rf_write_en;
    logic [HMC_RF_RWIDTH-1:0] rf_read_data;
    logic                     rf_invalid_address;
    logic                     rf_access_complete;

    modport master (
        input  req_valid, req_write, req_address, req_wdata, resp_ready,
               rf_read_data, rf_invalid_address, rf_access_complete,
        output req_ready, resp_valid, resp_rdata, resp_error, resp_timeout,
               rf_address, rf_write_data, rf_read_en, rf_write_en
    );

    modport slave (
        output req_valid, req_write, req_address, req_wdata, resp_ready,
               rf_read_data, rf_invalid_address, rf_access_complete,
        input  req_ready, resp_valid, resp_rdata, resp_error, resp_timeout,
               rf_address, rf_write_data, rf_read_en, rf_write_en
    );
endinterface

// File: rtl/hmc_rf_access_master.sv
// hmc_rf_access_master: single-outstanding bridge from a valid/ready register request to the HMC RF enable protocol
//  clk_hmc   : clock, rising edge
//  res_n_hmc : asynchronous active-low reset
//  bus       : hmc_rf_access_master_if.master (request, response and RF port signals)
//  Optional macro HMC_RF_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES cycles without rf_access_complete
module hmc_rf_access_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_hmc,
    input  logic                   res_n_hmc,
    hmc_rf_access_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
`ifdef HMC_RF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign bus.resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            state             <= IDLE;
            bus.req_ready     <= 1'b0;
            bus.resp_valid    <= 1'b0;
            bus.resp_rdata    <= '0;
            bus.resp_error    <= 1'b0;
            bus.rf_address    <= '0;
            bus.rf_write_data <= '0;
            bus.rf_read_en    <= 1'b0;
            bus.rf_write_en   <= 1'b0;
`ifdef HMC_RF_TIMEOUT_EN
            bus.resp_timeout  <= 1'b0;
            cnt               <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        state             <= ACCESS;
                        bus.req_ready     <= 1'b0;
                        bus.rf_address    <= bus.req_address;
                        bus.rf_write_data <= bus.req_write ? bus.req_wdata : '0;
                        bus.rf_write_en   <= bus.req_write;
                        bus.rf_read_en    <= !bus.req_write;
`ifdef HMC_RF_TIMEOUT_EN
                        cnt               <= '0;
`endif
                    end
                end
                ACCESS: begin
                    // rf_write_en still identifies the access type on the completion edge
                    if (bus.rf_access_complete) begin
                        state           <= RESP;
                        bus.rf_read_en  <= 1'b0;
                        bus.rf_write_en <= 1'b0;
                        bus.resp_rdata  <= bus.rf_write_en ? '0 : bus.rf_read_data;
                        bus.resp_error  <= bus.rf_invalid_address;
                        bus.resp_valid  <= 1'b1;
`ifdef HMC_RF_TIMEOUT_EN
                        bus.resp_timeout <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state            <= RESP;
                        bus.rf_read_en   <= 1'b0;
                        bus.rf_write_en  <= 1'b0;
                        bus.resp_rdata   <= '0;
                        bus.resp_error   <= 1'b1;
                        bus.resp_timeout <= 1'b1;
                        bus.resp_valid   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hmc_rf_access_master.sv
// tb_hmc_rf_access_master: directed and randomized self-checking bench for hmc_rf_access_master
module tb_hmc_rf_access_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nerr = 0;
    int   nchk = 0;
    logic [63:0] mem [16];

    always #5 clk = ~clk;

    hmc_rf_access_master_if #(.HMC_RF_AWIDTH(4), .HMC_RF_WWIDTH(64), .HMC_RF_RWIDTH(64)) bus ();

    hmc_rf_access_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk_hmc  (clk),
        .res_n_hmc(rst_n),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full access: request, RF wait of wt cycles (complete in cycle wt), response held for hold cycles.
    // With nv set, a following request is presented while the response is still pending.
    task automatic xact(input logic wr, input logic [3:0] a, input logic [63:0] wd, input int wt,
                        input logic inv, input logic [63:0] rd, input int hold,
                        input logic nv = 1'b0, input logic nwr = 1'b0,
                        input logic [3:0] na = 4'h0, input logic [63:0] nwd = 64'h0);
        logic [63:0] er;
        er = wr ? 64'h0 : rd;
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_address = a;
        bus.req_wdata   = wd;
        chk("req_ready_idle", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("req_ready_busy", bus.req_ready, 0);
        for (int i = 0; i <= wt; i++) begin
            chk("rf_write_en", bus.rf_write_en, wr);
            chk("rf_read_en", bus.rf_read_en, !wr);
            chk("rf_address", bus.rf_address, a);
            chk("rf_write_data", bus.rf_write_data, wr ? wd : 64'h0);
            chk("resp_valid_access", bus.resp_valid, 0);
            bus.rf_access_complete = (i == wt);
            bus.rf_invalid_address = inv;
            bus.rf_read_data       = (i == wt) ? rd : {$urandom, $urandom};
            @(negedge clk);
        end
        bus.rf_access_complete = 1'b0;
        bus.rf_invalid_address = 1'b0;
        chk("en_cleared", {bus.rf_read_en, bus.rf_write_en}, 0);
        chk("resp_valid", bus.resp_valid, 1);
        chk("resp_rdata", bus.resp_rdata, er);
        chk("resp_error", bus.resp_error, inv);
        chk("resp_timeout", bus.resp_timeout, 0);
        if (nv) begin
            bus.req_valid   = 1'b1;
            bus.req_write   = nwr;
            bus.req_address = na;
            bus.req_wdata   = nwd;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.resp_valid, 1);
            chk("hold_rdata", bus.resp_rdata, er);
            chk("hold_error", bus.resp_error, inv);
            chk("hold_req_ready", bus.req_ready, 0);
            chk("hold_no_access", {bus.rf_read_en, bus.rf_write_en}, 0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_done", bus.resp_valid, 0);
        chk("req_ready_after", bus.req_ready, 1);
        chk("no_access_after", {bus.rf_read_en, bus.rf_write_en}, 0);
        chk("rf_address_kept", bus.rf_address, a);
    endtask

    initial begin
        bus.req_valid = 0; bus.req_write = 0; bus.req_address = 0; bus.req_wdata = 0;
        bus.resp_ready = 0; bus.rf_read_data = 0; bus.rf_invalid_address = 0; bus.rf_access_complete = 0;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};

        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_en", {bus.rf_read_en, bus.rf_write_en}, 0);
        chk("rst_rf_address", bus.rf_address, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_error", {bus.resp_error, bus.resp_timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 1);

        xact(1'b1, 4'h2, 64'hDEAD_BEEF_0123_4567, 1, 1'b0, 64'h0, 0);
        mem[2] = 64'hDEAD_BEEF_0123_4567;
        xact(1'b0, 4'h5, 64'h0, 3, 1'b0, 64'h0000_0000_CAFE_F00D, 0);
        xact(1'b0, 4'hF, 64'h0, 0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1);

        bus.rf_access_complete = 1'b1;
        bus.rf_invalid_address = 1'b1;
        @(negedge clk);
        bus.rf_access_complete = 1'b0;
        bus.rf_invalid_address = 1'b0;
        chk("stray_complete_valid", bus.resp_valid, 0);
        chk("stray_complete_ready", bus.req_ready, 1);

        xact(1'b1, 4'h9, 64'h0BAD_F00D_5555_AAAA, 2, 1'b0, 64'h0, 5, 1'b1, 1'b0, 4'h2, 64'h0);
        xact(1'b0, 4'h2, 64'h0, 0, 1'b0, mem[2], 0);

        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_address = 4'h3; bus.req_wdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_write_en", bus.rf_write_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_write_en", bus.rf_write_en, 0);
        chk("async_rst_resp_valid", bus.resp_valid, 0);
        chk("async_rst_req_ready", bus.req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rf_access_complete = 1'b1;
        @(negedge clk);
        bus.rf_access_complete = 1'b0;
        chk("rel_req_ready", bus.req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("no_stale_resp", bus.resp_valid, 0);
            @(negedge clk);
        end

`ifdef HMC_RF_TIMEOUT_EN
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 4'h7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to_read_en", bus.rf_read_en, 1);
            chk("to_no_resp", bus.resp_valid, 0);
            @(negedge clk);
        end
        chk("to_read_en_drop", bus.rf_read_en, 0);
        chk("to_resp_valid", bus.resp_valid, 1);
        chk("to_resp_error", bus.resp_error, 1);
        chk("to_resp_timeout", bus.resp_timeout, 1);
        chk("to_resp_rdata", bus.resp_rdata, 0);
        bus.rf_access_complete = 1'b1;
        bus.rf_read_data = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        bus.rf_access_complete = 1'b0;
        chk("late_valid", bus.resp_valid, 1);
        chk("late_timeout", bus.resp_timeout, 1);
        chk("late_rdata", bus.resp_rdata, 0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("to_done", bus.resp_valid, 0);
        xact(1'b0, 4'h4, 64'h0, 7, 1'b0, 64'h0000_0042_0000_0042, 0);
`endif

        for (int n = 0; n < 25; n++) begin
            logic        wr;
            logic [3:0]  a;
            logic [63:0] wd;
            logic        inv;
            wr  = 1'($urandom_range(0, 1));
            a   = 4'($urandom_range(0, 15));
            wd  = {$urandom, $urandom};
            inv = ($urandom_range(0, 7) == 0);
            xact(wr, a, wd, $urandom_range(0, 4), inv, mem[a], $urandom_range(0, 3));
            if (wr && !inv) mem[a] = wd;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
